gameover_text_overlay: RTL and testbench

Pixel-pipeline stage that sits directly upstream of the game-over character ROM and font ROM. It maps the incoming VGA raster position to a character index (`char_xy`) and glyph line (`char_line`), consumes the returned 8-pixel glyph row, and overlays blinking text on the video stream. All VGA timing signals are delayed to stay aligned with the overlay. The text is shown only while `game_over` is high.

---
 rtl/gameover_text_overlay.sv | 201 ++++++++++++++++++++
 tb/tb_gameover_text_overlay.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gameover_text_overlay.sv
// Game-over text overlay: maps the raster position to character/glyph
// addresses, overlays the returned glyph row with blinking text and keeps
// all VGA timing aligned through a fixed 4-cycle pipeline.
module gameover_text_overlay #(
  parameter logic [10:0] X_POS        = 11'd256,
  parameter logic [10:0] Y_POS        = 11'd300,
  parameter int unsigned TEXT_COLS    = 32,
  parameter int unsigned TEXT_ROWS    = 1,
  parameter logic [11:0] TEXT_COLOR   = 12'hFF0,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_over,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [11:0] char_xy,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [10:0] X_END      = 11'(int'(X_POS) + 8 * TEXT_COLS);
  localparam logic [10:0] Y_END      = 11'(int'(Y_POS) + 16 * TEXT_ROWS);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam int unsigned TW         = 38; // hcount, vcount, 4 sync/blank, rgb

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHOW_ON  = 2'd1,
    SHOW_OFF = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_fcnt;
  logic [7:0]  w_fcnt_nxt;

  logic        w_frame_start;
  logic        w_in_box;
  logic [6:0]  w_col;
  logic [4:0]  w_row;
  logic [3:0]  w_line;
  logic [2:0]  w_bit;
  logic [TW-1:0] w_timing;

  logic [3:0]  r_line_d1;
  logic [2:0]  r_bit_d1, r_bit_d2, r_bit_d3;
  logic        r_in_box_d1, r_in_box_d2, r_in_box_d3;
  logic        r_vis_d1, r_vis_d2, r_vis_d3;
  logic [TW-1:0] r_tim_d1, r_tim_d2, r_tim_d3;

  logic        w_hblnk_d3, w_vblnk_d3;
  logic [11:0] w_rgb_d3;

  // Raster decode: box membership and character/glyph address
  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);
  assign w_in_box      = (hcount_in >= X_POS) && (hcount_in < X_END) &&
                         (vcount_in >= Y_POS) && (vcount_in < Y_END);
  assign w_col         = 7'((hcount_in - X_POS) >> 3);
  assign w_row         = 5'((vcount_in - Y_POS) >> 4);
  assign w_line        = 4'(vcount_in - Y_POS);
  assign w_bit         = ~3'(hcount_in - X_POS);
  assign w_timing      = {hcount_in, vcount_in, hsync_in, vsync_in,
                          hblnk_in, vblnk_in, rgb_in};

  assign w_hblnk_d3 = r_tim_d3[13];
  assign w_vblnk_d3 = r_tim_d3[12];
  assign w_rgb_d3   = r_tim_d3[11:0];

  // Blink FSM state register, advanced only at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Blink FSM next-state and frame counter
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (w_frame_start) begin
      if (!game_over) begin
        w_state_nxt = IDLE;
        w_fcnt_nxt  = 8'd0;
      end else begin
        case (r_state)
          IDLE: begin
            w_state_nxt = SHOW_ON;
            w_fcnt_nxt  = 8'd0;
          end
          SHOW_ON, SHOW_OFF: begin
            if (r_fcnt == BLINK_LAST) begin
              w_state_nxt = (r_state == SHOW_ON) ? SHOW_OFF : SHOW_ON;
              w_fcnt_nxt  = 8'd0;
            end else begin
              w_fcnt_nxt  = r_fcnt + 8'd1;
            end
          end
          default: begin
            w_state_nxt = IDLE;
            w_fcnt_nxt  = 8'd0;
          end
        endcase
      end
    end
  end

  // Stage 1: character address, glyph coordinates, visibility, timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy     <= 12'd0;
      r_line_d1   <= 4'd0;
      r_bit_d1    <= 3'd0;
      r_in_box_d1 <= 1'b0;
      r_vis_d1    <= 1'b0;
      r_tim_d1    <= '0;
    end else begin
      char_xy     <= w_in_box ? {w_row, w_col} : 12'd0;
      r_line_d1   <= w_in_box ? w_line : 4'd0;
      r_bit_d1    <= w_bit;
      r_in_box_d1 <= w_in_box;
      r_vis_d1    <= (r_state == SHOW_ON);
      r_tim_d1    <= w_timing;
    end
  end

  // Stage 2: glyph line to the font ROM alongside the returned char code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_line   <= 4'd0;
      r_bit_d2    <= 3'd0;
      r_in_box_d2 <= 1'b0;
      r_vis_d2    <= 1'b0;
      r_tim_d2    <= '0;
    end else begin
      char_line   <= r_line_d1;
      r_bit_d2    <= r_bit_d1;
      r_in_box_d2 <= r_in_box_d1;
      r_vis_d2    <= r_vis_d1;
      r_tim_d2    <= r_tim_d1;
    end
  end

  // Stage 3: align pixel attributes with the returned glyph row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_d3    <= 3'd0;
      r_in_box_d3 <= 1'b0;
      r_vis_d3    <= 1'b0;
      r_tim_d3    <= '0;
    end else begin
      r_bit_d3    <= r_bit_d2;
      r_in_box_d3 <= r_in_box_d2;
      r_vis_d3    <= r_vis_d2;
      r_tim_d3    <= r_tim_d2;
    end
  end

  // Stage 4: output registers; blanking overrides text
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= 11'd0;
      vcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= r_tim_d3[37:27];
      vcount_out <= r_tim_d3[26:16];
      hsync_out  <= r_tim_d3[15];
      vsync_out  <= r_tim_d3[14];
      hblnk_out  <= w_hblnk_d3;
      vblnk_out  <= w_vblnk_d3;
      if (w_hblnk_d3 || w_vblnk_d3)
        rgb_out <= 12'd0;
      else if (r_in_box_d3 && r_vis_d3 && char_pixels[r_bit_d3])
        rgb_out <= TEXT_COLOR;
      else
        rgb_out <= w_rgb_d3;
    end
  end

endmodule

// File: tb/tb_gameover_text_overlay.sv
// Directed bench for gameover_text_overlay: reset, pass-through, addressing,
// glyph overlay, blink sequence, box edges and blanking.
module tb_gameover_text_overlay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_over;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic [11:0] char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_checks = 0;
  int n_errors = 0;

  gameover_text_overlay #(
    .X_POS(11'd256), .Y_POS(11'd300), .TEXT_COLS(32), .TEXT_ROWS(1),
    .TEXT_COLOR(12'hFF0), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_over(game_over),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_pixels(char_pixels),
    .char_xy(char_xy), .char_line(char_line),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic [10:0] h, input logic [10:0] v,
                        input logic [11:0] rgb, input logic hb, input logic vb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = rgb;
    hblnk_in  = hb;
    vblnk_in  = vb;
  endtask

  // Hold a pixel for 4 cycles so its result reaches rgb_out
  task automatic probe(input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] rgb, input logic hb, input logic vb);
    set_px(h, v, rgb, hb, vb);
    repeat (4) tick();
  endtask

  // One cycle at raster (0,0), then park away from it
  task automatic frame_start();
    set_px(11'd0, 11'd0, 12'h000, 1'b1, 1'b1);
    tick();
    set_px(11'd1, 11'd1, 12'h000, 1'b1, 1'b1);
  endtask

  logic [10:0] oh [5];
  logic [10:0] ov [5];

  initial begin
    rst_n = 1'b0;
    game_over = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    char_pixels = 8'h00;
    set_px(11'd0, 11'd0, 12'h000, 1'b0, 1'b0);

    // Reset with random inputs: all outputs stay zero
    for (int i = 0; i < 4; i++) begin
      set_px(11'($urandom), 11'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
      hsync_in = 1'($urandom);
      vsync_in = 1'($urandom);
      game_over = 1'($urandom);
      char_pixels = 8'($urandom);
      tick();
      check("rst_rgb", 16'(rgb_out), 16'h0);
      check("rst_xy", 16'(char_xy), 16'h0);
      check("rst_hcnt", 16'(hcount_out), 16'h0);
      check("rst_sync", 16'({hsync_out, vsync_out, hblnk_out, vblnk_out, char_line}), 16'h0);
    end

    // Release: hsync_out follows hsync_in exactly 4 cycles later
    game_over = 1'b0;
    char_pixels = 8'h00;
    set_px(11'd10, 11'd10, 12'h000, 1'b0, 1'b0);
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("rel_hsync_early", 16'(hsync_out), 16'h0);
    end
    tick();
    check("rel_hsync", 16'(hsync_out), 16'h1);
    check("rel_hcnt", 16'(hcount_out), 16'd10);
    hsync_in = 1'b0;

    // Pass-through with game_over low
    frame_start();
    char_pixels = 8'hFF;
    probe(11'd264, 11'd300, 12'h0A5, 1'b0, 1'b0);
    check("pass_rgb", 16'(rgb_out), 16'h0A5);
    check("pass_xy", 16'(char_xy), 16'h001);

    // Outside the box and on the exclusive edges: address is zero
    oh[0] = 11'd255; ov[0] = 11'd300;
    oh[1] = 11'd512; ov[1] = 11'd300;
    oh[2] = 11'd256; ov[2] = 11'd316;
    oh[3] = 11'd256; ov[3] = 11'd299;
    oh[4] = 11'd600; ov[4] = 11'd310;
    for (int i = 0; i < 5; i++) begin
      set_px(oh[i], ov[i], 12'h0A5, 1'b0, 1'b0);
      tick();
      check("out_xy", 16'(char_xy), 16'h0);
      tick();
      check("out_line", 16'(char_line), 16'h0);
    end

    // Addressing: col 5, line 7
    set_px(11'd299, 11'd307, 12'h0A5, 1'b0, 1'b0);
    tick();
    check("addr_xy", 16'(char_xy), 16'h005);
    tick();
    check("addr_line", 16'(char_line), 16'd7);

    // Last cell of the box
    set_px(11'd511, 11'd315, 12'h0A5, 1'b0, 1'b0);
    tick();
    check("corner_xy", 16'(char_xy), 16'h01F);
    tick();
    check("corner_line", 16'(char_line), 16'd15);

    // Glyph overlay on frame 1 (visible)
    game_over = 1'b1;
    frame_start();
    char_pixels = 8'b1000_0000;
    for (int dx = 0; dx < 8; dx++) begin
      probe(11'(256 + dx), 11'd302, 12'h123, 1'b0, 1'b0);
      check("glyph_px", 16'(rgb_out), (dx == 0) ? 16'hFF0 : 16'h123);
    end
    char_pixels = 8'b0000_0001;
    probe(11'd263, 11'd302, 12'h123, 1'b0, 1'b0);
    check("glyph_dx7", 16'(rgb_out), 16'hFF0);

    // Blink with 2 frames per phase: frames 2..5 are on, off, off, on
    char_pixels = 8'b1000_0000;
    frame_start();
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b0);
    check("blink_f2", 16'(rgb_out), 16'hFF0);
    frame_start();
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b0);
    check("blink_f3", 16'(rgb_out), 16'h123);
    frame_start();
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b0);
    check("blink_f4", 16'(rgb_out), 16'h123);
    frame_start();
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b0);
    check("blink_f5", 16'(rgb_out), 16'hFF0);

    // Blanking wins over a set glyph bit
    probe(11'd256, 11'd302, 12'h123, 1'b1, 1'b0);
    check("hblank_rgb", 16'(rgb_out), 16'h000);
    check("hblank_out", 16'(hblnk_out), 16'h1);
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b1);
    check("vblank_rgb", 16'(rgb_out), 16'h000);

    // Box edges with every glyph bit set
    char_pixels = 8'hFF;
    probe(11'd511, 11'd302, 12'h123, 1'b0, 1'b0);
    check("edge_x_in", 16'(rgb_out), 16'hFF0);
    probe(11'd512, 11'd302, 12'h123, 1'b0, 1'b0);
    check("edge_x_out", 16'(rgb_out), 16'h123);
    probe(11'd256, 11'd315, 12'h123, 1'b0, 1'b0);
    check("edge_y_in", 16'(rgb_out), 16'hFF0);
    probe(11'd256, 11'd316, 12'h123, 1'b0, 1'b0);
    check("edge_y_out", 16'(rgb_out), 16'h123);
    check("edge_vcnt", 16'(vcount_out), 16'd316);

    // Deassert mid-frame: text stays until the next frame start
    game_over = 1'b0;
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b0);
    check("deassert_same", 16'(rgb_out), 16'hFF0);
    frame_start();
    probe(11'd256, 11'd302, 12'h123, 1'b0, 1'b0);
    check("deassert_next", 16'(rgb_out), 16'h123);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
